// File: rtl/axi4_slave_mem_wait.sv
// AXI4 slave memory model with FIXED/INCR/WRAP bursts, byte strobes and an
// optional SLVERR address window. Read and write channels run independent
// state machines with one burst outstanding per direction.
// Optional macro STALL_INJECT_EN: a 16-bit LFSR injects pseudo-random wait
// states on arready/awready/wready and delays new read beats.
module axi4_slave_mem_wait #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int          MEM_BYTES  = 65536,
    parameter logic [31:0] ERR_BASE   = 32'hF000,
    parameter logic [31:0] ERR_SIZE   = 32'h0,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready
);
    localparam int         STRB_W    = DATA_WIDTH / 8;
    localparam int         LANE_SH   = $clog2(STRB_W);
    localparam int         MEM_WORDS = MEM_BYTES / STRB_W;
    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam logic [2:0] SIZE_MAX  = 3'(LANE_SH);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Word-wide storage, not reset; index = byte address >> log2(bytes per word)
    logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

    // Address of the following beat; WRAP stays inside the aligned (len+1)*bytes block
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes_v;
        logic [ADDR_WIDTH-1:0] mask_v;
        logic [31:0]           blk_v;
        logic [ADDR_WIDTH-1:0] res_v;
        bytes_v = ADDR_WIDTH'(32'd1 << size);
        blk_v   = ({24'd0, len} + 32'd1) << size;
        mask_v  = ADDR_WIDTH'(blk_v - 32'd1);
        case (burst)
            2'b00:   res_v = a;
            2'b01:   res_v = a + bytes_v;
            2'b10:   res_v = (a & ~mask_v) | ((a + bytes_v) & mask_v);
            default: res_v = a;
        endcase
        return res_v;
    endfunction

    // A beat is in error if it hits the SLVERR window or the burst is malformed
    function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] a,
            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] a64;
        logic        in_win;
        logic        wrap_bad;
        a64      = 64'(a);
        in_win   = (ERR_SIZE != 32'd0) && (a64 >= 64'(ERR_BASE)) &&
                   (a64 < (64'(ERR_BASE) + 64'(ERR_SIZE)));
        wrap_bad = (burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                         (len == 8'd7) || (len == 8'd15));
        return in_win || (size > SIZE_MAX) || wrap_bad || (burst == 2'b11);
    endfunction

    // Memory word index; upper address bits fall away, giving modulo MEM_BYTES
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> LANE_SH);
    endfunction

    logic w_hs_stall;
    logic w_r_stall;

`ifdef STALL_INJECT_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) that schedules the injected wait states
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_lfsr <= STALL_SEED;
        else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_hs_stall = (r_lfsr[1:0] == 2'b00);
    assign w_r_stall  = (r_lfsr[3:2] == 2'b00);
`else
    assign w_hs_stall = 1'b0;
    assign w_r_stall  = 1'b0;
`endif

    // ---------------- read channel ----------------
    r_state_t              r_rstate;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen, r_rcnt;
    logic [2:0]            r_rsize;
    logic [1:0]            r_rburst;

    logic                  w_ar_hs, w_r_hs, w_r_present, w_rb_err;
    logic [ADDR_WIDTH-1:0] w_rb_addr;
    logic [7:0]            w_rb_cnt, w_rb_len;
    logic [2:0]            w_rb_size;
    logic [1:0]            w_rb_burst;
    logic [DATA_WIDTH-1:0] w_rb_data;

    assign s_axi_arready = r_arready & ~w_hs_stall;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign w_ar_hs       = s_axi_arvalid & s_axi_arready;
    assign w_r_hs        = r_rvalid & s_axi_rready;

    // Select the beat to present next: first beat from AR, next beat after a
    // handshake, or a beat held back by an injected delay
    always_comb begin
        w_rb_addr   = r_raddr;
        w_rb_cnt    = r_rcnt;
        w_rb_len    = r_rlen;
        w_rb_size   = r_rsize;
        w_rb_burst  = r_rburst;
        w_r_present = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_rb_addr   = s_axi_araddr;
                w_rb_cnt    = 8'd0;
                w_rb_len    = s_axi_arlen;
                w_rb_size   = s_axi_arsize;
                w_rb_burst  = s_axi_arburst;
                w_r_present = w_ar_hs;
            end
            R_DATA: begin
                if (w_r_hs) begin
                    w_rb_addr   = next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
                    w_rb_cnt    = r_rcnt + 8'd1;
                    w_r_present = ~r_rlast;
                end else begin
                    w_r_present = ~r_rvalid;
                end
            end
            default: w_r_present = 1'b0;
        endcase
        w_rb_err  = beat_err(w_rb_addr, w_rb_len, w_rb_size, w_rb_burst);
        w_rb_data = w_rb_err ? {DATA_WIDTH{1'b0}} : mem[word_idx(w_rb_addr)];
    end

    // Read FSM; beat outputs load only when a new beat is presented so they hold under backpressure
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_rresp   <= RESP_OKAY;
            r_rid     <= {ID_WIDTH{1'b0}};
            r_raddr   <= {ADDR_WIDTH{1'b0}};
            r_rlen    <= 8'd0;
            r_rcnt    <= 8'd0;
            r_rsize   <= 3'd0;
            r_rburst  <= 2'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= s_axi_arid;
                        r_rlen    <= s_axi_arlen;
                        r_rsize   <= s_axi_arsize;
                        r_rburst  <= s_axi_arburst;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs && r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else begin
                        r_rstate  <= R_DATA;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
            if (w_r_present) begin
                r_raddr <= w_rb_addr;
                r_rcnt  <= w_rb_cnt;
                if (w_r_stall) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rb_data;
                    r_rresp  <= w_rb_err ? RESP_SLV : RESP_OKAY;
                    r_rlast  <= (w_rb_cnt == w_rb_len);
                end
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t              r_wstate;
    logic                  r_awready, r_wready, r_bvalid, r_werr;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen;
    logic [8:0]            r_wcnt;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst;

    logic                  w_aw_hs, w_w_hs, w_b_hs, w_wb_err, w_wlast_bad, w_mem_we;
    logic [IDX_W-1:0]      w_widx;

    assign s_axi_awready = r_awready & ~w_hs_stall;
    assign s_axi_wready  = r_wready & ~w_hs_stall;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_bid;
    assign w_aw_hs       = s_axi_awvalid & s_axi_awready;
    assign w_w_hs        = s_axi_wvalid & s_axi_wready;
    assign w_b_hs        = r_bvalid & s_axi_bready;
    assign w_wb_err      = beat_err(r_waddr, r_wlen, r_wsize, r_wburst);
    assign w_wlast_bad   = s_axi_wlast != (r_wcnt == {1'b0, r_wlen});
    assign w_mem_we      = w_w_hs & ~w_wb_err & (r_wstate == W_DATA);
    assign w_widx        = word_idx(r_waddr);

    // Write FSM; the response accumulates every beat error plus any misplaced wlast
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= {ID_WIDTH{1'b0}};
            r_werr    <= 1'b0;
            r_waddr   <= {ADDR_WIDTH{1'b0}};
            r_wlen    <= 8'd0;
            r_wcnt    <= 9'd0;
            r_wsize   <= 3'd0;
            r_wburst  <= 2'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_bid     <= s_axi_awid;
                        r_waddr   <= s_axi_awaddr;
                        r_wlen    <= s_axi_awlen;
                        r_wsize   <= s_axi_awsize;
                        r_wburst  <= s_axi_awburst;
                        r_wcnt    <= 9'd0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                        r_wcnt  <= r_wcnt + 9'd1;
                        if (s_axi_wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_wb_err | w_wlast_bad) ? RESP_SLV : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_werr   <= r_werr | w_wb_err | w_wlast_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Strobed memory write; same-edge reads of the word still see the old data
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_wstrb[i]) mem[w_widx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem_wait.sv
// Self-checking bench: table of directed bursts, hand-written backpressure and
// reset sequences, a 256-beat copy and randomized bursts against a burst-level
// reference model of the memory.
module tb_axi4_slave_mem_wait;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid, rid, awid, bid;
    logic [15:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic [31:0] rdata, wdata;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [0:16383];

    always #5 clk = ~clk;

    axi4_slave_mem_wait #(.ERR_SIZE(32'h100)) dut (
        .aclk(clk), .aresetn(rst_n),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte address of beat b, computed directly from the burst start
    function automatic int m_addr(int start, int b, int len, int size, int burst);
        int bytes = 1 << size;
        int blk = (len + 1) * bytes;
        int base;
        case (burst)
            1: return (start + b * bytes) % 65536;
            2: begin
                base = start - (start % blk);
                return base + ((start - base + b * bytes) % blk);
            end
            default: return start;
        endcase
    endfunction

    function automatic bit m_err(int a, int len, int size, int burst);
        return (a >= 'hF000 && a < 'hF100) || size > 2 || burst == 3 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic wait_ready(input int which, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            case (which)
                0: ok = arready;
                1: ok = awready;
                default: ok = wready;
            endcase
            if (ok) break;
        end
    endtask

    task automatic do_read(input logic [3:0] id, input int addr, len, size, burst,
                           input int hold_at, output logic [1:0] orr);
        bit ok;
        int beat, cyc, a, hold;
        bit e;
        logic [34:0] snap;
        orr = 2'b00; hold = hold_at;
        arid = id; araddr = 16'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        wait_ready(0, ok);
        if (!ok) begin check("ar_handshake_timeout", 0, 1); arvalid = 1'b0; return; end
        @(posedge clk); #1 arvalid = 1'b0;
`ifndef STALL_INJECT_EN
        check("rvalid_cycle_after_ar", rvalid, 1);
`endif
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 3000) begin
            if (beat == hold) begin
                rready = 1'b0; ok = 1'b0;
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (rvalid) begin ok = 1'b1; break; end
                end
                if (!ok) check("hold_rvalid_timeout", 0, 1);
                else begin
                    snap = {rdata, rresp, rlast};
                    repeat (5) begin
                        @(negedge clk);
                        check("hold_beat_stable", {rvalid, rdata, rresp, rlast}, {1'b1, snap});
                    end
                end
                @(posedge clk); #1; hold = -1;
            end
            rready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rvalid && rready) begin
                a = m_addr(addr, beat, len, size, burst);
                e = m_err(a, len, size, burst);
                check($sformatf("rdata_b%0d", beat), rdata, e ? 32'h0 : ref_mem[a >> 2]);
                check($sformatf("rresp_b%0d", beat), rresp, e ? 2'b10 : 2'b00);
                check($sformatf("rlast_b%0d", beat), rlast, beat == len);
                check("rid", rid, id);
                orr = orr | rresp;
                beat++;
            end
            @(posedge clk); #1; cyc++;
        end
        rready = 1'b0;
        if (beat <= len) check("r_beats_timeout", beat, len + 1);
    endtask

    task automatic do_write(input logic [3:0] id, input int addr, len, size, burst,
                            input logic [31:0] wd, input logic [3:0] ws, input bit rnd,
                            input int nb, output logic [1:0] bres);
        bit ok, e, experr;
        int a;
        logic [31:0] d;
        logic [3:0] s;
        bres = 2'b11; experr = 1'b0;
        awid = id; awaddr = 16'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        wait_ready(1, ok);
        if (!ok) begin check("aw_handshake_timeout", 0, 1); awvalid = 1'b0; return; end
        @(posedge clk); #1 awvalid = 1'b0;
`ifndef STALL_INJECT_EN
        check("wready_cycle_after_aw", wready, 1);
`endif
        for (int b = 0; b < nb; b++) begin
            if (rnd) begin d = $urandom; s = 4'($urandom_range(0, 15)); end
            else begin d = wd; s = ws; end
            wdata = d; wstrb = s; wlast = (b == nb - 1); wvalid = 1'b1;
            wait_ready(2, ok);
            if (!ok) begin check("w_handshake_timeout", 0, 1); wvalid = 1'b0; return; end
            @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
            a = m_addr(addr, b, len, size, burst);
            e = m_err(a, len, size, burst);
            if (!e) for (int l = 0; l < 4; l++) if (s[l]) ref_mem[a >> 2][8*l +: 8] = d[8*l +: 8];
            experr = experr | e | ((b == nb - 1) != (b == len));
            if (b < nb - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
`ifndef STALL_INJECT_EN
        check("bvalid_cycle_after_wlast", bvalid, 1);
`endif
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            bready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bvalid && bready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin check("b_handshake_timeout", 0, 1); bready = 1'b0; return; end
        check("bresp", bresp, experr ? 2'b10 : 2'b00);
        check("bid", bid, id);
        bres = bresp;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        int          addr, len, size, burst;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          nb;
        logic [1:0]  exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[13];
        logic [1:0] res;
        logic [31:0] saved_f000, saved_f004;
        bit ok;
        int a, len, size, burst, nb;

        tv[0]  = '{0, 'h0000, 15, 2, 1, 32'h0, 4'h0, 0, 2'b00};
        tv[1]  = '{1, 'h1000, 3, 2, 1, 32'hFFFF_FFFF, 4'b0101, 4, 2'b00};
        tv[2]  = '{0, 'h1000, 3, 2, 1, 32'h0, 4'h0, 0, 2'b00};
        tv[3]  = '{0, 'h0008, 3, 2, 2, 32'h0, 4'h0, 0, 2'b00};
        tv[4]  = '{0, 'h0008, 2, 2, 2, 32'h0, 4'h0, 0, 2'b10};
        tv[5]  = '{1, 'hF000, 1, 2, 1, 32'h1234_5678, 4'hF, 2, 2'b10};
        tv[6]  = '{0, 'hEFF8, 3, 2, 1, 32'h0, 4'h0, 0, 2'b10};
        tv[7]  = '{0, 'h0004, 3, 2, 0, 32'h0, 4'h0, 0, 2'b00};
        tv[8]  = '{0, 'h0000, 0, 2, 3, 32'h0, 4'h0, 0, 2'b10};
        tv[9]  = '{0, 'h0000, 0, 3, 1, 32'h0, 4'h0, 0, 2'b10};
        tv[10] = '{1, 'h3000, 3, 2, 1, 32'h5555_AAAA, 4'hF, 2, 2'b10};
        tv[11] = '{1, 'h2004, 1, 2, 2, 32'hCAFE_F00D, 4'hF, 2, 2'b00};
        tv[12] = '{0, 'h2004, 1, 2, 2, 32'h0, 4'h0, 0, 2'b00};

        for (int i = 0; i < 16384; i++) ref_mem[i] = $urandom;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) ref_mem[1024 + i] = 32'h0;
        for (int i = 0; i < 16384; i++) dut.mem[i] = ref_mem[i];
        saved_f000 = ref_mem[15360];
        saved_f004 = ref_mem[15361];

        #2;
        check("reset_ctrl", {arready, awready, wready, rvalid, bvalid, rlast}, 6'b0);
        check("reset_data", {rdata, rresp, bresp, rid, bid}, 44'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (tv[i].wr)
                do_write(4'(i), tv[i].addr, tv[i].len, tv[i].size, tv[i].burst,
                         tv[i].wd, tv[i].ws, 1'b0, tv[i].nb, res);
            else
                do_read(4'(i), tv[i].addr, tv[i].len, tv[i].size, tv[i].burst, -1, res);
            check($sformatf("vec%0d_resp", i), res, tv[i].exp);
        end
        check("mem_strb_merge_w0", dut.mem[1024], 32'h00FF_00FF);
        check("mem_strb_merge_w3", dut.mem[1027], 32'h00FF_00FF);
        check("mem_err_untouched_0", dut.mem[15360], saved_f000);
        check("mem_err_untouched_1", dut.mem[15361], saved_f004);
        check("mem_wrap_write", dut.mem[2048], 32'hCAFE_F00D);

        // rready held low for 5 cycles on the final beat: rdata/rlast must not move
        do_read(4'h3, 'h0000, 7, 2, 1, 7, res);
        check("hold_read_resp", res, 2'b00);

        // reset in the middle of a write burst
        awid = 4'h5; awaddr = 16'h5000; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
        awvalid = 1'b1;
        wait_ready(1, ok);
        check("rst_seq_aw_accepted", ok, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            wdata = 32'hD000_0000 + 32'(b); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            wait_ready(2, ok);
            @(posedge clk); #1 wvalid = 1'b0;
            if (ok) ref_mem[20480/4 + b] = 32'hD000_0000 + 32'(b);
            check("rst_seq_w_accepted", ok, 1);
        end
        rst_n = 1'b0;
        #1;
        check("rst_async_ctrl", {arready, awready, wready, rvalid, bvalid, rlast}, 6'b0);
        check("rst_async_data", {rdata, rresp, bresp, rid, bid}, 44'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_write(4'h6, 'h5004, 0, 2, 1, 32'h1234_5678, 4'hF, 1'b0, 1, res);
        check("post_reset_write_resp", res, 2'b00);
        do_read(4'h7, 'h5000, 7, 2, 1, -1, res);
        check("post_reset_read_resp", res, 2'b00);

        // 256-beat INCR copy out and back
        do_write(4'h8, 'h4000, 255, 2, 1, 32'h0, 4'h0, 1'b1, 256, res);
        check("long_write_resp", res, 2'b00);
        do_read(4'h9, 'h4000, 255, 2, 1, -1, res);
        check("long_read_resp", res, 2'b00);

        // randomized bursts
        for (int t = 0; t < 40; t++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            size = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            if (burst == 2) begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    3: len = 15;
                    default: len = 2;
                endcase
            end else len = $urandom_range(0, 15);
            a = $urandom_range(0, 65535) & ~((1 << size) - 1);
            if ($urandom_range(0, 1) == 1) begin
                nb = (len > 0 && $urandom_range(0, 7) == 0) ? len : len + 1;
                do_write(4'($urandom_range(0, 15)), a, len, size, burst, 32'h0, 4'h0, 1'b1, nb, res);
            end else begin
                do_read(4'($urandom_range(0, 15)), a, len, size, burst, -1, res);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4_slave_mem_wait.md
Name: axi4_slave_mem_wait

Overview:
Parametrised next-generation AXI4 slave memory model used as the DMA system target in simulation and FPGA bring-up.
- Generalised data width (32/64/128).
- FIXED, INCR and WRAP burst types, per-byte strobes.
- Configurable SLVERR address window.
- Optional pseudo-random wait-state injection to stress DMA master handshakes.
- Read and write channels run independent FSMs, one burst outstanding per direction.

Parameters:
ADDR_WIDTH, 16, byte address bits decoded; higher address bits ignored (modulo MEM_BYTES).
DATA_WIDTH, 32, data bus width in bits; 32, 64 or 128.
ID_WIDTH, 4, AXI ID width.
MEM_BYTES, 65536, memory size in bytes; power of two, at most 2^ADDR_WIDTH.
ERR_BASE, 32'hF000, first byte address of the SLVERR window.
ERR_SIZE, 32'h0, SLVERR window size in bytes; 0 disables the window.
STALL_SEED, 16'hACE1, LFSR seed (used only with STALL_INJECT_EN).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address channel
s_axi_arvalid  in  1 ; s_axi_arready  out  1
s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data channel
s_axi_rvalid  out  1 ; s_axi_rready  in  1
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
s_axi_awvalid  in  1 ; s_axi_awready  out  1
s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel
s_axi_wvalid  in  1 ; s_axi_wready  out  1
s_axi_bid/bresp  out  ID_WIDTH/2  write response
s_axi_bvalid  out  1 ; s_axi_bready  in  1

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous, active-low.
- Reset values: all ready/valid outputs 0; rlast 0; rdata, rresp, bresp, rid, bid all 0. Memory array `mem` (DATA_WIDTH-wide words, index = byte addr >> log2(DATA_WIDTH/8)) is not reset; benches preload it hierarchically.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1; an AR handshake latches id, addr, len, size and burst, then moves to R_DATA.
  - R_DATA: first rvalid is asserted the cycle after the AR handshake.
  - rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
  - rlast=1 on beat arlen+1.
  - After the rlast handshake, return to R_IDLE with arready=1 on the next cycle.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1; an AW handshake latches the burst fields.
  - W_DATA: wready=1 from the next cycle; each accepted beat writes only the lanes whose wstrb bit is set.
  - The wlast handshake moves to W_RESP; bvalid is asserted the following cycle and held until bready, then return to W_IDLE.
  - wlast on the wrong beat: the burst still ends on wlast; bresp=SLVERR.
- Address update per beat, with bytes = 1<<size:
  - FIXED: address unchanged.
  - INCR: address + bytes.
  - WRAP: wraps within an aligned block of (len+1)*bytes.
  - Memory index wraps modulo MEM_BYTES.
- Errors:
  - resp=SLVERR (2'b10) if any of: beat address inside [ERR_BASE, ERR_BASE+ERR_SIZE); size > log2(DATA_WIDTH/8); WRAP with len not in {1,3,7,15}; burst type 2'b11.
  - Error read beats return rdata=0. Error write beats do not modify memory.
  - bresp is the OR of all beat errors in the burst. Otherwise resp=OKAY.
- Simultaneous events: a read and a write to the same word in the same cycle, the read returns pre-write data. The AR and AW channels are fully concurrent.
- Reset mid-burst: both FSMs go to idle immediately and the in-flight bursts are dropped; memory keeps any beats already written.

Optional Feature:
STALL_INJECT_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with STALL_SEED at reset, advances every cycle.
  - arready, awready and wready are forced low on cycles where lfsr[1:0]==2'b00.
  - A new rvalid beat is delayed one cycle where lfsr[3:2]==2'b00.
  - A beat already presented with rvalid=1 is never withdrawn.
- Undefined: zero wait states; timing exactly as in Behaviour.

Test Plan:
- Preload mem[0..15]=A000_0000+i; INCR read araddr 0, arlen 15, size 2 -> 16 beats with rdata=A000_0000+i, rlast only on beat 16, rresp=OKAY, rid=arid.
- INCR write awaddr 0x1000, awlen 3, wstrb 4'b0101, wdata FFFF_FFFF, preload 0 -> mem words read back 00FF_00FF, bresp OKAY, bvalid 1 cycle after wlast.
- WRAP read araddr 0x0008, arlen 3, size 2 -> addresses 0x8, 0xC, 0x0, 0x4. WRAP with arlen 2 -> all beats SLVERR, rdata 0.
- ERR_BASE=0xF000, ERR_SIZE=0x100; write 2 beats at 0xF000 -> bresp SLVERR, memory unchanged.
- Hold rready low 5 cycles mid-burst -> rdata and rlast stable. Assert aresetn low mid write burst -> all valids and readies 0 asynchronously, next AW accepted after release.
- STALL_INJECT_EN with a 256-beat INCR copy driven by the DMA -> data identical to zero-wait run, no protocol violation, completes within 2x baseline cycles.
